// File: rtl/spi_slave_module_pkg.sv
// Shared definitions for the SPI mode-0 responder: FSM encoding, SPI_In bit
// positions, widths, the AT45 status opcode and a saturating counter helper.
package spi_slave_module_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    // SPI_In bit positions
    localparam int unsigned CS_IDX   = 2;
    localparam int unsigned SCK_IDX  = 1;
    localparam int unsigned MOSI_IDX = 0;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);
    localparam logic [BYTE_W-1:0]    OP_STATUS = 8'hD7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Byte counter increment that sticks at all-ones
    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
        return (v == {BYTE_W{1'b1}}) ? v : v + BYTE_W'(1);
    endfunction

endpackage

// File: rtl/spi_slave_module_if.sv
// Bus bundle for spi_slave_module.
//   SPI_In[2:0] : {CS_n, SCK, MOSI}, asynchronous to the system clock
//   SPI_Out     : MISO
//   Rx_Data/Rx_Valid            : received byte + 1-cycle strobe
//   Tx_Data/Tx_Load/Tx_Ready    : reply byte holding-register write port
//   Tx_Underrun/Busy/Frame_Done/Byte_Cnt : frame status
// slave modport = responder side, master modport = user/bench side.
interface spi_slave_module_if;
    import spi_slave_module_pkg::*;

    logic [2:0]        SPI_In;
    logic              SPI_Out;
    logic [BYTE_W-1:0] Rx_Data;
    logic              Rx_Valid;
    logic [BYTE_W-1:0] Tx_Data;
    logic              Tx_Load;
    logic              Tx_Ready;
    logic              Tx_Underrun;
    logic              Busy;
    logic              Frame_Done;
    logic [BYTE_W-1:0] Byte_Cnt;

    modport slave (
        input  SPI_In, Tx_Data, Tx_Load,
        output SPI_Out, Rx_Data, Rx_Valid, Tx_Ready, Tx_Underrun,
               Busy, Frame_Done, Byte_Cnt
    );

    modport master (
        output SPI_In, Tx_Data, Tx_Load,
        input  SPI_Out, Rx_Data, Rx_Valid, Tx_Ready, Tx_Underrun,
               Busy, Frame_Done, Byte_Cnt
    );

endinterface

// File: rtl/spi_sync_edge_module.sv
// Synchroniser plus edge detector for one asynchronous SPI wire.
//   clk    : system clock
//   din    : asynchronous input
//   sync   : synchronised level (registered)
//   rise_c : combinational 1-cycle pulse on synchronised rising edge
//   fall_c : combinational 1-cycle pulse on synchronised falling edge
// The flops carry no reset on purpose: they keep tracking the wire through
// reset, so releasing reset can never fabricate a CS or SCK edge.
module spi_sync_edge_module #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        chain <= {chain[SYNC_STAGES-2:0], din};
        prev  <= chain[SYNC_STAGES-1];
    end

    assign sync   = chain[SYNC_STAGES-1];
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_slave_module.sv
// SPI mode-0, MSB-first responder oversampled on CLK.
//   CLK  : system clock
//   RSTn : synchronous active-low reset
//   bus  : spi_slave_module_if.slave (SPI wires, rx strobe, tx holding reg,
//          frame status)
// Optional feature macro: SPI_SLAVE_STATUS_EN -- after a first byte of 8'hD7
// every further byte of that frame replies STATUS_VAL from internal logic.
module spi_slave_module
    import spi_slave_module_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_TX     = 8'hFF,
    parameter logic [BYTE_W-1:0] STATUS_VAL  = 8'hAC
) (
    input logic               CLK,
    input logic               RSTn,
    spi_slave_module_if.slave bus
);

    logic cs_s, cs_rise_c, cs_fall_c;
    logic sck_s, sck_rise_c, sck_fall_c;
    logic unused_sck_level;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0]     rx_shift_q, tx_shift_q, hold_q;

    logic start_c, reload_c, rx_bit_c, tx_bit_c, end_frame_c;
    logic use_status_c, take_hold_c, underrun_c, load_accept_c;
    logic [BYTE_W-1:0] reload_byte_c, rx_byte_c;

    spi_sync_edge_module #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(CLK), .din(bus.SPI_In[CS_IDX]),
        .sync(cs_s), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    spi_sync_edge_module #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(CLK), .din(bus.SPI_In[SCK_IDX]),
        .sync(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
    );

    // Only the SCK edges matter; the level is left unconsumed.
    assign unused_sck_level = sck_s;

    // MOSI needs no edge detection, just the same synchroniser depth
    always_ff @(posedge CLK) begin
        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.SPI_In[MOSI_IDX]};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; CS rise overrides everything
    always_comb begin
        state_d = state_q;
        if (cs_rise_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cs_fall_c) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_SHIFT;
                ST_SHIFT: state_d = ST_SHIFT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode: per-cycle datapath actions; an SCK edge coinciding with
    // CS rise is dropped
    always_comb begin
        start_c     = 1'b0;
        reload_c    = 1'b0;
        rx_bit_c    = 1'b0;
        tx_bit_c    = 1'b0;
        end_frame_c = cs_rise_c && (state_q != ST_IDLE);
        if (!cs_rise_c) begin
            case (state_q)
                ST_LOAD: begin
                    start_c  = 1'b1;
                    reload_c = 1'b1;
                end
                ST_SHIFT: begin
                    if (sck_rise_c) begin
                        rx_bit_c = 1'b1;
                    end else if (sck_fall_c) begin
                        if (bit_cnt_q == '0) reload_c = 1'b1;
                        else                 tx_bit_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    // Status-read mode: first byte of the frame was the AT45 status opcode
    logic status_q;
    always_ff @(posedge CLK) begin
        if (!RSTn || start_c || end_frame_c)
            status_q <= 1'b0;
        else if (rx_bit_c && bit_cnt_q == LAST_BIT && bus.Byte_Cnt == '0 &&
                 rx_byte_c == OP_STATUS)
            status_q <= 1'b1;
    end
    assign use_status_c = status_q;
`else
    assign use_status_c = 1'b0;
`endif

    // Reply source: status byte, queued byte (holding full = !Tx_Ready) or fill
    assign take_hold_c   = reload_c && !use_status_c && !bus.Tx_Ready;
    assign underrun_c    = reload_c && !use_status_c && bus.Tx_Ready;
    assign reload_byte_c = use_status_c  ? STATUS_VAL :
                           !bus.Tx_Ready ? hold_q     : IDLE_TX;
    assign load_accept_c = bus.Tx_Load && bus.Tx_Ready;
    assign rx_byte_c     = {rx_shift_q[BYTE_W-2:0], mosi_s};

    // Datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            bus.SPI_Out     <= 1'b1;
            bus.Rx_Data     <= '0;
            bus.Rx_Valid    <= 1'b0;
            bus.Tx_Ready    <= 1'b1;
            bus.Tx_Underrun <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Frame_Done  <= 1'b0;
            bus.Byte_Cnt    <= '0;
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= IDLE_TX;
            hold_q          <= '0;
        end else begin
            bus.Rx_Valid    <= 1'b0;
            bus.Tx_Underrun <= 1'b0;
            bus.Frame_Done  <= 1'b0;
            bus.Busy        <= ~cs_s;

            // Load and consume are exclusive: load needs empty, consume full
            if (load_accept_c) begin
                hold_q       <= bus.Tx_Data;
                bus.Tx_Ready <= 1'b0;
            end else if (take_hold_c) begin
                bus.Tx_Ready <= 1'b1;
            end

            if (end_frame_c) begin
                bus.Frame_Done <= 1'b1;
                bus.SPI_Out    <= 1'b1;
                bit_cnt_q      <= '0;
            end

            if (start_c) begin
                bus.Byte_Cnt <= '0;
                bit_cnt_q    <= '0;
            end

            if (reload_c) begin
                tx_shift_q      <= reload_byte_c;
                bus.SPI_Out     <= reload_byte_c[BYTE_W-1];
                bus.Tx_Underrun <= underrun_c;
            end

            if (tx_bit_c) begin
                bus.SPI_Out <= tx_shift_q[BYTE_W-2];
                tx_shift_q  <= {tx_shift_q[BYTE_W-2:0], 1'b1};
            end

            if (rx_bit_c) begin
                rx_shift_q <= rx_byte_c;
                if (bit_cnt_q == LAST_BIT) begin
                    bus.Rx_Data  <= rx_byte_c;
                    bus.Rx_Valid <= 1'b1;
                    bus.Byte_Cnt <= sat_inc(bus.Byte_Cnt);
                    bit_cnt_q    <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                end
            end
        end
    end

endmodule
